bloom_filter_bitarray_ctrl: RTL and testbench
=============================================

# bloom_filter_bitarray_ctrl

Sequential consumer of the seven 11-bit bloom-filter hash indices. Owns a 2048-bit membership array stored as a 64 x 32-bit single-port synchronous RAM. Performs insert, query and clear requests by walking the seven indices with read-modify-write cycles, then returns a hit/miss response. Sits directly downstream of the 72-bit key hasher in the BRAM-method bloom filter.

## Interface
- `WORDS`, default 64: RAM depth. Fixed at 64; index[10:5] selects the word, index[4:0] selects the bit.
- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_op`  in  2  request opcode:
  - 00 query
  - 01 insert
  - 10 clear
  - 11 reserved
- `hash_0` … `hash_6`  in  11 each  bit indices. Sampled only on the accept edge.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_hit`  out  1  result bit:
  - query: all seven bits were set.
  - insert: all seven bits were already set before the insert.
  - clear and reserved: 0.
- `fill_count`  out  12  number of set bits in the array, 0..2048.

## Operation
- FSM states: INIT, IDLE, RD, EVAL, CLR, RESP.
- Reset:
  - FSM → INIT, word pointer = 0, k = 0.
  - req_ready = 0, rsp_valid = 0, rsp_hit = 0, fill_count = 0.
  - RAM contents are not reset.
- INIT: writes 0 to words 0..63, one word per cycle, then goes to IDLE.
- IDLE:
  - req_ready = 1.
  - A request is accepted when req_valid && req_ready. On that edge the block latches req_op and all seven hashes and sets k = 0.
- Query/insert: RD → EVAL is repeated for k = 0..6.
  - RD: RAM address = hash_k[10:5].
  - EVAL: b = rdata[hash_k[4:0]]. If b = 0, miss flag ← 1.
  - EVAL, insert with b = 0: write rdata | (1 << hash_k[4:0]) to the same address and increment fill_count.
  - After EVAL with k = 6, go to RESP.
- Repeated indices: the write in EVAL lands before the next RD.
  - Duplicate indices within one request therefore see the updated bit.
  - fill_count increments once per distinct newly-set bit.
- Clear: CLR writes 0 to words 0..63, sets fill_count = 0, then goes to RESP with rsp_hit = 0.
- Reserved opcode: goes to RESP on the next cycle with rsp_hit = 0. No RAM access.
- RESP:
  - rsp_valid = 1, rsp_hit = ~miss.
  - rsp_valid and rsp_hit stay stable until rsp_ready.
  - On the rsp_valid && rsp_ready edge, go to IDLE.
- req_ready = 0 in every state except IDLE. Requests are never overlapped.
- Reset asserted mid-operation aborts the operation and re-runs INIT. An in-flight response is dropped.

## Timing
- Edge numbering: the accept edge is edge 0; cycle n follows edge n-1.
- Query or insert without early exit:
  - RD_k occupies cycle 2k+1 and EVAL_k occupies cycle 2k+2.
  - rsp_valid rises in cycle 15.
- Clear: CLR occupies cycles 1..64; rsp_valid rises in cycle 65.
- Reserved opcode: rsp_valid rises in cycle 1.
- After reset release: INIT occupies cycles 1..64; req_ready = 1 from cycle 65.
- fill_count updates on the EVAL edge that writes the bit; it is visible the next cycle.
- RAM: 1-cycle read latency, write-first, one access per cycle.

## Configuration
- `BLOOM_QUERY_EARLY_EXIT_EN`
  - Defined: a query goes from EVAL_k to RESP as soon as b = 0. A miss at index k gives rsp_valid in cycle 2k+3. Inserts always walk all seven indices.
  - Undefined: queries always walk all seven indices. Response latency is fixed at 15 cycles.

## Test plan
- Reset, then hold req_valid = 1 → req_ready = 0 until cycle 65. After that, querying hashes 0,1,2,3,4,5,6 → rsp_hit = 0 and fill_count = 0.
- Insert hashes 5,100,700,1023,1024,2000,2047 → rsp_hit = 0, fill_count = 7, rsp_valid in cycle 15. A query with the same hashes → rsp_hit = 1. Re-inserting them → rsp_hit = 1 with fill_count still 7.
- Insert with all seven hashes = 37 → fill_count +1 only. A query of 37 ×7 → rsp_hit = 1.
- Query 2047,0,0,0,0,0,0 against an empty array:
  - Macro defined → rsp_valid in cycle 3.
  - Macro undefined → rsp_valid in cycle 15.
  - rsp_hit = 0 in both builds.
- Hold rsp_ready = 0 for 10 cycles with rsp_valid high → response stays stable and req_ready = 0. Then clear → rsp_valid in cycle 65, fill_count = 0, and a subsequent query of the earlier inserted set → rsp_hit = 0.
- Pull rst_n low during EVAL_3 of an insert → all outputs are at reset values immediately and INIT re-runs (64 cycles). A query afterwards → rsp_hit = 0.

Source files
------------

// File: rtl/bloom_filter_bitarray_ctrl.sv
// rtl/bloom_filter_bitarray_ctrl.sv - bloom filter 2048-bit membership array controller (optional: BLOOM_QUERY_EARLY_EXIT_EN)
module bloom_filter_bitarray_ctrl #(
  parameter int WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [10:0] hash_0,
  input  logic [10:0] hash_1,
  input  logic [10:0] hash_2,
  input  logic [10:0] hash_3,
  input  logic [10:0] hash_4,
  input  logic [10:0] hash_5,
  input  logic [10:0] hash_6,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_hit,
  output logic [11:0] fill_count
);

  localparam logic [1:0] OP_QUERY  = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [5:0] LAST_WORD = 6'd63;
  localparam logic [2:0] LAST_K    = 3'd6;

  typedef enum logic [2:0] {INIT, IDLE, RD, EVAL, CLR, RESP} state_t;

  state_t      state_q, state_d;
  logic [5:0]  ptr_q;
  logic [2:0]  k_q;
  logic        miss_q;
  logic [1:0]  op_q;
  logic [11:0] fill_q;
  logic [10:0] h_q [7];

  logic [31:0] mem [WORDS];
  logic [5:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [10:0] h_sel;
  logic        cur_bit;
  logic        ins_new;

  assign h_sel   = h_q[k_q];
  assign cur_bit = mem_rdata[h_sel[4:0]];
  assign ins_new = (op_q == OP_INSERT) && !cur_bit;

  // Single-port synchronous RAM, write-first, contents never reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      mem_rdata     <= mem_wdata;
    end else begin
      mem_rdata     <= mem[mem_addr];
    end
  end

  // Next-state, RAM port and handshake decode
  always_comb begin
    state_d   = state_q;
    mem_addr  = ptr_q;
    mem_we    = 1'b0;
    mem_wdata = 32'd0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      INIT: begin
        mem_we = 1'b1;
        if (ptr_q == LAST_WORD) state_d = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          case (req_op)
            OP_QUERY, OP_INSERT: state_d = RD;
            OP_CLEAR:            state_d = CLR;
            default:             state_d = RESP;
          endcase
        end
      end
      RD: begin
        mem_addr = h_sel[10:5];
        state_d  = EVAL;
      end
      EVAL: begin
        mem_addr = h_sel[10:5];
        if (ins_new) begin
          mem_we    = 1'b1;
          mem_wdata = mem_rdata | (32'd1 << h_sel[4:0]);
        end
        if (k_q == LAST_K) begin
          state_d = RESP;
`ifdef BLOOM_QUERY_EARLY_EXIT_EN
        end else if ((op_q == OP_QUERY) && !cur_bit) begin
          state_d = RESP;
`endif
        end else begin
          state_d = RD;
        end
      end
      CLR: begin
        mem_we = 1'b1;
        if (ptr_q == LAST_WORD) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  // State register plus word pointer, index counter, miss flag and fill counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= 6'd0;
      k_q     <= 3'd0;
      miss_q  <= 1'b0;
      op_q    <= OP_QUERY;
      fill_q  <= 12'd0;
      for (int i = 0; i < 7; i++) h_q[i] <= 11'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        INIT, CLR: begin
          ptr_q  <= ptr_q + 6'd1;
          fill_q <= 12'd0;
        end
        IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            k_q    <= 3'd0;
            ptr_q  <= 6'd0;
            // clear and reserved opcodes always answer with hit = 0
            miss_q <= req_op[1];
            h_q[0] <= hash_0;
            h_q[1] <= hash_1;
            h_q[2] <= hash_2;
            h_q[3] <= hash_3;
            h_q[4] <= hash_4;
            h_q[5] <= hash_5;
            h_q[6] <= hash_6;
          end
        end
        EVAL: begin
          k_q <= k_q + 3'd1;
          if (!cur_bit) miss_q <= 1'b1;
          if (ins_new) fill_q <= fill_q + 12'd1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_hit    = (state_q == RESP) && !miss_q;
  assign fill_count = fill_q;

endmodule

// File: tb/tb_bloom_filter_bitarray_ctrl.sv
// tb/tb_bloom_filter_bitarray_ctrl.sv - directed self-checking bench for bloom_filter_bitarray_ctrl
module tb_bloom_filter_bitarray_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [10:0] h0 = '0, h1 = '0, h2 = '0, h3 = '0, h4 = '0, h5 = '0, h6 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_hit;
  logic [11:0] fill_count;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef BLOOM_QUERY_EARLY_EXIT_EN
  localparam int MISS0_LAT = 3;
`else
  localparam int MISS0_LAT = 15;
`endif

  bloom_filter_bitarray_ctrl #(.WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .hash_0(h0), .hash_1(h1), .hash_2(h2), .hash_3(h3),
    .hash_4(h4), .hash_5(h5), .hash_6(h6),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic set_hashes(input logic [10:0] a0, a1, a2, a3, a4, a5, a6);
    h0 = a0; h1 = a1; h2 = a2; h3 = a3; h4 = a4; h5 = a5; h6 = a6;
  endtask

  task automatic set_s;
    set_hashes(11'd5, 11'd100, 11'd700, 11'd1023, 11'd1024, 11'd2000, 11'd2047);
  endtask

  // Issue one request with the current hashes; lat is the cycle index of rsp_valid (edge 0 = accept)
  task automatic do_req(input logic [1:0] op, output int lat, output logic hit, output logic [11:0] fc);
    int n;
    @(negedge clk);
    req_op = op;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    hit = rsp_hit;
    fc  = fill_count;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  // Release reset just after an edge (that edge counts as edge 0) and expect INIT for 64 cycles
  task automatic release_and_check_init(input string tag);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (req_ready !== (i == 64)) begin
        n_bad++;
        $display("FAIL %s_req_ready cycle %0d: got %b expected %b", tag, i + 1, req_ready, (i == 64));
      end
    end
  endtask

  task automatic test_reset;
    int lat; logic hit; logic [11:0] fc;
    rst_n = 1'b0;
    req_valid = 1'b1;
    set_hashes(11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_hit, fill_count} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rr=%b rv=%b hit=%b fc=%0d expected all 0",
               req_ready, rsp_valid, rsp_hit, fill_count);
    end
    release_and_check_init("init");
    req_valid = 1'b0;
    do_req(2'b00, lat, hit, fc);
    n_cmp++;
    if (hit !== 1'b0) begin n_bad++; $display("FAIL empty_query_hit: got %b expected 0", hit); end
    n_cmp++;
    if (fc !== 12'd0) begin n_bad++; $display("FAIL empty_query_fill: got %0d expected 0", fc); end
  endtask

  task automatic test_miss_latency;
    int lat; logic hit; logic [11:0] fc;
    set_hashes(11'd2047, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0);
    do_req(2'b00, lat, hit, fc);
    n_cmp++;
    if (lat !== MISS0_LAT) begin n_bad++; $display("FAIL miss_latency: got %0d expected %0d", lat, MISS0_LAT); end
    n_cmp++;
    if (hit !== 1'b0) begin n_bad++; $display("FAIL miss_hit: got %b expected 0", hit); end
  endtask

  task automatic test_insert_query;
    int lat; logic hit; logic [11:0] fc;
    set_s();
    do_req(2'b01, lat, hit, fc);
    n_cmp++;
    if (hit !== 1'b0) begin n_bad++; $display("FAIL insert_hit: got %b expected 0", hit); end
    n_cmp++;
    if (fc !== 12'd7) begin n_bad++; $display("FAIL insert_fill: got %0d expected 7", fc); end
    n_cmp++;
    if (lat !== 15) begin n_bad++; $display("FAIL insert_latency: got %0d expected 15", lat); end
    do_req(2'b00, lat, hit, fc);
    n_cmp++;
    if (hit !== 1'b1) begin n_bad++; $display("FAIL query_hit: got %b expected 1", hit); end
    n_cmp++;
    if (lat !== 15) begin n_bad++; $display("FAIL query_latency: got %0d expected 15", lat); end
    do_req(2'b01, lat, hit, fc);
    n_cmp++;
    if (hit !== 1'b1) begin n_bad++; $display("FAIL reinsert_hit: got %b expected 1", hit); end
    n_cmp++;
    if (fc !== 12'd7) begin n_bad++; $display("FAIL reinsert_fill: got %0d expected 7", fc); end
  endtask

  task automatic test_duplicate;
    int lat; logic hit; logic [11:0] fc;
    set_hashes(11'd37, 11'd37, 11'd37, 11'd37, 11'd37, 11'd37, 11'd37);
    do_req(2'b01, lat, hit, fc);
    n_cmp++;
    if (hit !== 1'b0) begin n_bad++; $display("FAIL dup_insert_hit: got %b expected 0", hit); end
    n_cmp++;
    if (fc !== 12'd8) begin n_bad++; $display("FAIL dup_insert_fill: got %0d expected 8", fc); end
    do_req(2'b00, lat, hit, fc);
    n_cmp++;
    if (hit !== 1'b1) begin n_bad++; $display("FAIL dup_query_hit: got %b expected 1", hit); end
  endtask

  task automatic test_reserved;
    int lat; logic hit; logic [11:0] fc;
    set_s();
    do_req(2'b11, lat, hit, fc);
    n_cmp++;
    if (lat !== 1) begin n_bad++; $display("FAIL reserved_latency: got %0d expected 1", lat); end
    n_cmp++;
    if (hit !== 1'b0) begin n_bad++; $display("FAIL reserved_hit: got %b expected 0", hit); end
    n_cmp++;
    if (fc !== 12'd8) begin n_bad++; $display("FAIL reserved_fill: got %0d expected 8", fc); end
  endtask

  task automatic test_stall_clear;
    int lat; int n; logic hit; logic [11:0] fc;
    set_s();
    @(negedge clk);
    req_op = 2'b00;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 200) begin @(posedge clk); #1 n++; end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({rsp_valid, rsp_hit, req_ready} !== 3'b110) begin
        n_bad++;
        $display("FAIL stall_hold %0d: got rv=%b hit=%b rr=%b expected rv=1 hit=1 rr=0",
                 i, rsp_valid, rsp_hit, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL stall_release: got rv=%b rr=%b expected rv=0 rr=1", rsp_valid, req_ready);
    end
    do_req(2'b10, lat, hit, fc);
    n_cmp++;
    if (lat !== 65) begin n_bad++; $display("FAIL clear_latency: got %0d expected 65", lat); end
    n_cmp++;
    if (hit !== 1'b0) begin n_bad++; $display("FAIL clear_hit: got %b expected 0", hit); end
    n_cmp++;
    if (fc !== 12'd0) begin n_bad++; $display("FAIL clear_fill: got %0d expected 0", fc); end
    do_req(2'b00, lat, hit, fc);
    n_cmp++;
    if (hit !== 1'b0) begin n_bad++; $display("FAIL post_clear_query_hit: got %b expected 0", hit); end
  endtask

  task automatic test_reset_midop;
    int lat; int n; logic hit; logic [11:0] fc;
    set_s();
    @(negedge clk);
    req_op = 2'b01;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_cmp++;
    if (fill_count !== 12'd3) begin n_bad++; $display("FAIL midop_fill_before: got %0d expected 3", fill_count); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_hit, fill_count} !== 15'd0) begin
      n_bad++;
      $display("FAIL midop_reset_outputs: got rr=%b rv=%b hit=%b fc=%0d expected all 0",
               req_ready, rsp_valid, rsp_hit, fill_count);
    end
    release_and_check_init("reinit");
    do_req(2'b00, lat, hit, fc);
    n_cmp++;
    if (hit !== 1'b0) begin n_bad++; $display("FAIL post_reset_query_hit: got %b expected 0", hit); end
    n_cmp++;
    if (fc !== 12'd0) begin n_bad++; $display("FAIL post_reset_fill: got %0d expected 0", fc); end
  endtask

  initial begin
    test_reset();
    test_miss_latency();
    test_insert_query();
    test_duplicate();
    test_reserved();
    test_stall_clear();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
